// File: rtl/apb_charmap_pkg.sv
// Shared definitions for the APB character-map front-end.
// Holds the address-region decode, the word-index bases of the MAP/GLYPH/CSR windows
// (all computed from COLS/ROWS/GLYPH_BITS), the CSR field positions and the FSM state type.
package apb_charmap_pkg;

    typedef enum logic [1:0] {
        RegMap,
        RegGlyph,
        RegCsr,
        RegNone
    } region_e;

    typedef enum logic [3:0] {
        StIdle,
        StDecode,
        StMapRd,
        StMapWr,
        StGlyRd,
        StGlyWr,
        StCsr,
        StWaitFill,
        StErr,
        StResp
    } state_e;

    // CSR word offsets from the CSR base
    localparam int unsigned CTRL_OFF   = 0;
    localparam int unsigned STATUS_OFF = 1;

    // CTRL / STATUS bit positions
    localparam int unsigned CTRL_START_BIT   = 0;
    localparam int unsigned CTRL_DONECLR_BIT = 1;
    localparam int unsigned CTRL_IE_BIT      = 2;
    localparam int unsigned STATUS_BUSY_BIT  = 0;
    localparam int unsigned STATUS_DONE_BIT  = 1;

    function automatic int unsigned pow2_ceil(input int unsigned x);
        return 32'd1 << $clog2(x);
    endfunction

    function automatic int unsigned glyph_words(input int unsigned gbits);
        return 256 * gbits / 32;
    endfunction

    // Glyph window sits on a boundary that is a multiple of both window sizes, so it is
    // naturally aligned to its own power-of-2 size.
    function automatic int unsigned glyph_base_w(input int unsigned cols, input int unsigned rows,
                                                 input int unsigned gbits);
        int unsigned m;
        int unsigned g;
        m = pow2_ceil(cols * rows);
        g = pow2_ceil(glyph_words(gbits));
        return (m > g) ? m : g;
    endfunction

    function automatic int unsigned csr_base_w(input int unsigned cols, input int unsigned rows,
                                               input int unsigned gbits);
        return glyph_base_w(cols, rows, gbits) + pow2_ceil(glyph_words(gbits));
    endfunction

    function automatic region_e decode_region(input logic [31:0] widx, input int unsigned cols,
                                              input int unsigned rows, input int unsigned gbits);
        int unsigned gb;
        int unsigned cb;
        gb = glyph_base_w(cols, rows, gbits);
        cb = csr_base_w(cols, rows, gbits);
        if (widx < cols * rows) begin
            return RegMap;
        end else if (widx >= gb && widx < gb + glyph_words(gbits)) begin
            return RegGlyph;
        end else if (widx == cb + CTRL_OFF || widx == cb + STATUS_OFF) begin
            return RegCsr;
        end
        return RegNone;
    endfunction

endpackage

// File: rtl/apb_charmap_ctrl_fill.sv
// Screen-fill engine: on start, writes a 16-bit value to every cell 0..Cells-1, one per cycle.
// Ports: start_i/value_i launch a fill, done_clr_i clears the sticky done flag (a same-cycle
// fill end wins), busy_o/done_o are status, we_o/addr_o/wdata_o form the map-port write request
// that the top muxes onto the RAM port while busy_o is high.
module charmap_fill_engine #(
    parameter int unsigned Cells = 2400,
    parameter int unsigned MAW   = 12
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [15:0]    value_i,
    input  logic           done_clr_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           we_o,
    output logic [MAW-1:0] addr_o,
    output logic [15:0]    wdata_o
);

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [MAW-1:0] cnt_q, cnt_d;
    logic [15:0]    val_q, val_d;
    logic           last;

    assign last = (cnt_q == MAW'(Cells - 1));

    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        cnt_d  = cnt_q;
        val_d  = val_q;
        if (busy_q) begin
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + MAW'(1);
            end
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            val_d  = value_i;
        end
        if (busy_q && last) begin
            done_d = 1'b1;
        end else if (done_clr_i) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            val_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            val_q  <= val_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign we_o    = busy_q;
    assign addr_o  = cnt_q;
    assign wdata_o = val_q;

endmodule

// File: rtl/apb_charmap_ctrl.sv
// APB slave front-end for the character-mapped VGA generator.
// Exposes the char/colour map, the glyph table and CTRL/STATUS CSRs over APB and drives generic
// synchronous RAM ports toward the chargen core.
// Ports: clk_i/rst_i (sync active-high), apb_* APB slave, map_* cell RAM port (shared with the
// fill engine), glyph_* glyph RAM port (writes are read-modify-write), irq_o = done & ie.
module apb_charmap_ctrl
    import apb_charmap_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 16,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned COLS           = 80,
    parameter int unsigned ROWS           = 30,
    parameter int unsigned GLYPH_BITS     = 128,
    parameter int unsigned MEM_RD_LAT     = 1,
    localparam int unsigned MAW           = $clog2(COLS * ROWS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0] apb_pwdata_i,
    input  logic [3:0]                apb_pstrb_i,
    input  logic                      apb_pwrite_i,
    input  logic                      apb_psel_i,
    input  logic                      apb_penable_i,
    output logic [APB_DATA_WIDTH-1:0] apb_prdata_o,
    output logic                      apb_pready_o,
    output logic                      apb_pslverr_o,
    output logic [MAW-1:0]            map_addr_o,
    output logic [15:0]               map_wdata_o,
    output logic [1:0]                map_wbe_o,
    output logic                      map_we_o,
    input  logic [15:0]               map_rdata_i,
    output logic [7:0]                glyph_addr_o,
    output logic [GLYPH_BITS-1:0]     glyph_wdata_o,
    output logic                      glyph_we_o,
    input  logic [GLYPH_BITS-1:0]     glyph_rdata_i,
    output logic                      irq_o
);

    localparam int unsigned Cells        = COLS * ROWS;
    localparam int unsigned WPG          = GLYPH_BITS / 32;
    localparam int unsigned KW           = (WPG > 1) ? $clog2(WPG) : 1;
    localparam int unsigned GLYPH_BASE_W = glyph_base_w(COLS, ROWS, GLYPH_BITS);
    localparam int unsigned CSR_BASE_W   = csr_base_w(COLS, ROWS, GLYPH_BITS);

    // Byte-merge one 32-bit APB word into word k of a glyph
    function automatic logic [GLYPH_BITS-1:0] glyph_merge(input logic [GLYPH_BITS-1:0] old,
                                                          input logic [KW-1:0] k,
                                                          input logic [31:0] wd,
                                                          input logic [3:0] st);
        logic [GLYPH_BITS-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) begin
                r[32*k + 8*b +: 8] = wd[8*b +: 8];
            end
        end
        return r;
    endfunction

    state_e                    state_q;
    logic [2:0]                cnt_q;
    logic                      wr_q;
    logic [31:0]               wdata_q;
    logic [3:0]                strb_q;
    logic [KW-1:0]             k_q;
    logic [31:0]               rdata_q;
    logic                      pready_q;
    logic                      pslverr_q;
    logic [31:0]               prdata_q;
    logic [MAW-1:0]            map_addr_q;
    logic [15:0]               map_wdata_q;
    logic [1:0]                map_wbe_q;
    logic                      map_we_q;
    logic [7:0]                glyph_addr_q;
    logic [GLYPH_BITS-1:0]     glyph_wdata_q;
    logic                      glyph_we_q;
    logic                      ie_q;
    logic [15:0]               fill_val_q;

    // Address decode of the live APB request
    logic [31:0]   widx;
    logic [31:0]   goff;
    logic [7:0]    gcode;
    logic [KW-1:0] gword;
    region_e       region;
    logic          is_ctrl;
    logic          is_status;
    logic          start_req;
    logic          err_c;
    logic          in_decode;
    logic          fill_start_c;
    logic          done_clr_c;
    logic [15:0]   new_fill_val;
    logic [31:0]   csr_rd;

    logic           fill_busy;
    logic           fill_done;
    logic           fill_we;
    logic [MAW-1:0] fill_addr;
    logic [15:0]    fill_wdata;

    always_comb begin
        widx      = 32'(apb_paddr_i) >> 2;
        goff      = widx - GLYPH_BASE_W;
        gcode     = 8'(goff / WPG);
        gword     = KW'(goff % WPG);
        region    = decode_region(widx, COLS, ROWS, GLYPH_BITS);
        is_ctrl   = (widx == CSR_BASE_W + CTRL_OFF);
        is_status = (widx == CSR_BASE_W + STATUS_OFF);
        start_req = apb_pwrite_i && (region == RegCsr) && is_ctrl && apb_pstrb_i[0]
                    && apb_pwdata_i[CTRL_START_BIT];
        err_c     = (apb_paddr_i[1:0] != 2'b00) || (region == RegNone)
                    || (apb_pwrite_i && (region == RegCsr) && is_status)
                    || (start_req && fill_busy);
        in_decode = (state_q == StDecode) && apb_psel_i && !err_c;
        fill_start_c = in_decode && start_req;
        done_clr_c   = in_decode && apb_pwrite_i && (region == RegCsr) && is_ctrl
                       && apb_pstrb_i[0] && apb_pwdata_i[CTRL_DONECLR_BIT];
        new_fill_val[7:0]  = apb_pstrb_i[2] ? apb_pwdata_i[23:16] : fill_val_q[7:0];
        new_fill_val[15:8] = apb_pstrb_i[3] ? apb_pwdata_i[31:24] : fill_val_q[15:8];
        csr_rd = '0;
        if (is_ctrl) begin
            csr_rd[CTRL_IE_BIT] = ie_q;
            csr_rd[31:16]       = fill_val_q;
        end else begin
            csr_rd[STATUS_BUSY_BIT] = fill_busy;
            csr_rd[STATUS_DONE_BIT] = fill_done;
        end
    end

    charmap_fill_engine #(
        .Cells (Cells),
        .MAW   (MAW)
    ) u_fill (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (fill_start_c),
        .value_i    (new_fill_val),
        .done_clr_i (done_clr_c),
        .busy_o     (fill_busy),
        .done_o     (fill_done),
        .we_o       (fill_we),
        .addr_o     (fill_addr),
        .wdata_o    (fill_wdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            strb_q        <= '0;
            k_q           <= '0;
            rdata_q       <= '0;
            pready_q      <= 1'b0;
            pslverr_q     <= 1'b0;
            prdata_q      <= '0;
            map_addr_q    <= '0;
            map_wdata_q   <= '0;
            map_wbe_q     <= '0;
            map_we_q      <= 1'b0;
            glyph_addr_q  <= '0;
            glyph_wdata_q <= '0;
            glyph_we_q    <= 1'b0;
            ie_q          <= 1'b0;
            fill_val_q    <= '0;
        end else begin
            // Pulse outputs default low; RESP lasts exactly one cycle
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            map_we_q   <= 1'b0;
            glyph_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (apb_psel_i && apb_penable_i) state_q <= StDecode;
                end
                StDecode: begin
                    if (!apb_psel_i) begin
                        state_q <= StIdle;
                    end else begin
                        wr_q    <= apb_pwrite_i;
                        wdata_q <= apb_pwdata_i;
                        strb_q  <= apb_pstrb_i;
                        k_q     <= gword;
                        cnt_q   <= '0;
                        if (err_c) begin
                            state_q <= StErr;
                        end else begin
                            case (region)
                                RegMap: begin
                                    if (fill_busy) begin
                                        state_q <= StWaitFill;
                                    end else begin
                                        map_addr_q <= widx[MAW-1:0];
                                        if (apb_pwrite_i) begin
                                            map_we_q    <= |apb_pstrb_i[1:0];
                                            map_wbe_q   <= apb_pstrb_i[1:0];
                                            map_wdata_q <= apb_pwdata_i[15:0];
                                            state_q     <= StMapWr;
                                        end else begin
                                            state_q <= StMapRd;
                                        end
                                    end
                                end
                                RegGlyph: begin
                                    glyph_addr_q <= gcode;
                                    state_q      <= StGlyRd;
                                end
                                RegCsr: begin
                                    if (apb_pwrite_i) begin
                                        if (is_ctrl) begin
                                            if (apb_pstrb_i[0]) ie_q <= apb_pwdata_i[CTRL_IE_BIT];
                                            fill_val_q <= new_fill_val;
                                        end
                                        rdata_q <= '0;
                                    end else begin
                                        rdata_q <= csr_rd;
                                    end
                                    state_q <= StCsr;
                                end
                                default: state_q <= StErr;
                            endcase
                        end
                    end
                end
                StWaitFill: begin
                    // Re-decode once the fill releases the map port
                    if (!apb_psel_i) state_q <= StIdle;
                    else if (!fill_busy) state_q <= StDecode;
                end
                StMapWr, StGlyWr: begin
                    pready_q <= apb_psel_i;
                    state_q  <= apb_psel_i ? StResp : StIdle;
                end
                StMapRd: begin
                    if (!apb_psel_i) begin
                        state_q <= StIdle;
                    end else if (cnt_q == 3'(MEM_RD_LAT)) begin
                        pready_q <= 1'b1;
                        prdata_q <= {16'b0, map_rdata_i};
                        state_q  <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StGlyRd: begin
                    // No psel check: an issued read-modify-write always completes
                    if (cnt_q == 3'(MEM_RD_LAT)) begin
                        if (wr_q) begin
                            glyph_wdata_q <= glyph_merge(glyph_rdata_i, k_q, wdata_q, strb_q);
                            glyph_we_q    <= 1'b1;
                            state_q       <= StGlyWr;
                        end else if (apb_psel_i) begin
                            pready_q <= 1'b1;
                            prdata_q <= glyph_rdata_i[32*k_q +: 32];
                            state_q  <= StResp;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StCsr: begin
                    pready_q <= apb_psel_i;
                    prdata_q <= apb_psel_i ? rdata_q : '0;
                    state_q  <= apb_psel_i ? StResp : StIdle;
                end
                StErr: begin
                    pready_q  <= apb_psel_i;
                    pslverr_q <= apb_psel_i;
                    state_q   <= apb_psel_i ? StResp : StIdle;
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign apb_prdata_o  = prdata_q;
    assign apb_pready_o  = pready_q;
    assign apb_pslverr_o = pslverr_q;

    // Fill engine owns the map port while busy
    assign map_we_o    = fill_busy ? fill_we : map_we_q;
    assign map_addr_o  = fill_busy ? fill_addr : map_addr_q;
    assign map_wdata_o = fill_busy ? fill_wdata : map_wdata_q;
    assign map_wbe_o   = fill_busy ? 2'b11 : map_wbe_q;

    assign glyph_addr_o  = glyph_addr_q;
    assign glyph_wdata_o = glyph_wdata_q;
    assign glyph_we_o    = glyph_we_q;

    assign irq_o = fill_done & ie_q;

endmodule

// File: tb/tb_apb_charmap_ctrl.sv
// Directed bench for apb_charmap_ctrl with default parameters and behavioural sync RAMs.
module tb_apb_charmap_ctrl;

    logic         clk;
    logic         rst;
    logic [15:0]  paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic         pwrite;
    logic         psel;
    logic         penable;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;
    logic [11:0]  map_addr;
    logic [15:0]  map_wdata;
    logic [1:0]   map_wbe;
    logic         map_we;
    logic [15:0]  map_rdata;
    logic [7:0]   glyph_addr;
    logic [127:0] glyph_wdata;
    logic         glyph_we;
    logic [127:0] glyph_rdata;
    logic         irq;

    int checks = 0;
    int errors = 0;

    apb_charmap_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .apb_paddr_i   (paddr),
        .apb_pwdata_i  (pwdata),
        .apb_pstrb_i   (pstrb),
        .apb_pwrite_i  (pwrite),
        .apb_psel_i    (psel),
        .apb_penable_i (penable),
        .apb_prdata_o  (prdata),
        .apb_pready_o  (pready),
        .apb_pslverr_o (pslverr),
        .map_addr_o    (map_addr),
        .map_wdata_o   (map_wdata),
        .map_wbe_o     (map_wbe),
        .map_we_o      (map_we),
        .map_rdata_i   (map_rdata),
        .glyph_addr_o  (glyph_addr),
        .glyph_wdata_o (glyph_wdata),
        .glyph_we_o    (glyph_we),
        .glyph_rdata_i (glyph_rdata),
        .irq_o         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAMs, read latency 1
    logic [15:0]  map_mem [0:2399];
    logic [127:0] glyph_mem [0:255];
    int           map_we_cnt = 0;
    int           gly_we_cnt = 0;
    logic [11:0]  last_map_addr;
    logic [15:0]  last_map_wdata;
    logic [1:0]   last_map_wbe;
    logic [127:0] last_gly_wdata;

    always @(posedge clk) begin
        if (map_we) begin
            if (map_wbe[0]) map_mem[map_addr][7:0] <= map_wdata[7:0];
            if (map_wbe[1]) map_mem[map_addr][15:8] <= map_wdata[15:8];
            map_we_cnt     <= map_we_cnt + 1;
            last_map_addr  <= map_addr;
            last_map_wdata <= map_wdata;
            last_map_wbe   <= map_wbe;
        end
        map_rdata <= map_mem[map_addr];
        if (glyph_we) begin
            glyph_mem[glyph_addr] <= glyph_wdata;
            gly_we_cnt     <= gly_we_cnt + 1;
            last_gly_wdata <= glyph_wdata;
        end
        glyph_rdata <= glyph_mem[glyph_addr];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apb(input logic [15:0] a, input logic wr, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic err,
                       output int lat);
        int  n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        rd   = '0;
        err  = 1'b0;
        lat  = -1;
        @(posedge clk); #1;
        paddr = a; pwrite = wr; pwdata = wd; pstrb = st; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        while (!seen && n < 6000) begin
            @(posedge clk); #1;
            n++;
            if (pready) begin
                seen = 1'b1;
                rd   = prdata;
                err  = pslverr;
                lat  = n - 1;
            end
        end
        psel = 1'b0; penable = 1'b0;
        check("pready_seen", seen, 1'b1);
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    int          cnt0;
    int          gcnt0;

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        for (int i = 0; i < 2400; i++) map_mem[i] = 16'h0;
        for (int i = 0; i < 256; i++) glyph_mem[i] = 128'h0;
        glyph_mem[8'h41] = 128'h33333333_22222222_11111111_00000000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", pready, 1'b0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_map_we", map_we, 1'b0);
        check("rst_map_addr", map_addr, 12'h0);
        check("rst_gly_we", glyph_we, 1'b0);
        check("rst_irq", irq, 1'b0);
        rst = 1'b0;
        apb(16'h5004, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("rst_status", rd, 32'h0);
        check("csr_rd_lat", lat, 2);

        // Map write / read
        cnt0 = map_we_cnt;
        apb(16'h0000, 1'b1, 32'h0000_2A41, 4'b0011, rd, err, lat);
        check("mapwr_lat", lat, 2);
        check("mapwr_err", err, 1'b0);
        check("mapwr_pulses", map_we_cnt - cnt0, 1);
        check("mapwr_addr", last_map_addr, 12'h0);
        check("mapwr_wdata", last_map_wdata, 16'h2A41);
        check("mapwr_wbe", last_map_wbe, 2'b11);
        apb(16'h0000, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("maprd_data", rd, 32'h0000_2A41);
        check("maprd_lat", lat, 3);
        apb(16'h0000, 1'b1, 32'hFFFF_55AA, 4'b1110, rd, err, lat);
        check("mapwr_wbe_hi", last_map_wbe, 2'b10);
        apb(16'h0000, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("maprd_merge", rd, 32'h0000_5541);
        cnt0 = map_we_cnt;
        apb(16'h0014, 1'b1, 32'h1234_5678, 4'b0000, rd, err, lat);
        check("map_nostrb_err", err, 1'b0);
        check("map_nostrb_pulses", map_we_cnt - cnt0, 0);

        // Glyph read-modify-write: glyph 0x41, word 2
        gcnt0 = gly_we_cnt;
        apb(16'h4418, 1'b1, 32'hDEAD_BEEF, 4'b0100, rd, err, lat);
        check("glywr_lat", lat, 4);
        check("glywr_rdata", rd, 32'h0);
        check("glywr_pulses", gly_we_cnt - gcnt0, 1);
        check("glywr_wdata", last_gly_wdata, 128'h33333333_22AD2222_11111111_00000000);
        apb(16'h4418, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("glyrd_data", rd, 32'h22AD_2222);
        check("glyrd_lat", lat, 3);

        // Error cases
        cnt0  = map_we_cnt;
        gcnt0 = gly_we_cnt;
        apb(16'h0002, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("err_misalign", err, 1'b1);
        check("err_misalign_rd", rd, 32'h0);
        apb(16'h0002, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, err, lat);
        check("err_misalign_wr", err, 1'b1);
        apb(16'h2580, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, err, lat);
        check("err_unmapped", err, 1'b1);
        apb(16'h5008, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("err_csr_hole", err, 1'b1);
        apb(16'h5004, 1'b1, 32'h0000_0003, 4'hF, rd, err, lat);
        check("err_status_wr", err, 1'b1);
        check("err_no_map_we", map_we_cnt - cnt0, 0);
        check("err_no_gly_we", gly_we_cnt - gcnt0, 0);

        // Screen fill
        cnt0 = map_we_cnt;
        apb(16'h5000, 1'b1, 32'h0707_0005, 4'hF, rd, err, lat);
        check("fill_start_err", err, 1'b0);
        apb(16'h5004, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("fill_busy", rd, 32'h1);
        apb(16'h5000, 1'b1, 32'h0707_0005, 4'hF, rd, err, lat);
        check("fill_restart_err", err, 1'b1);
        apb(16'h0190, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("fill_wait_data", rd, 32'h0000_0707);
        check("fill_wait_long", lat > 100, 1'b1);
        check("fill_pulses", map_we_cnt - cnt0, 2400);
        check("fill_cell0", map_mem[0], 16'h0707);
        check("fill_cell2399", map_mem[2399], 16'h0707);
        apb(16'h5004, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("fill_done", rd, 32'h2);
        check("fill_irq", irq, 1'b1);
        apb(16'h5000, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("ctrl_rd", rd, 32'h0707_0004);
        apb(16'h5000, 1'b1, 32'h0707_0006, 4'hF, rd, err, lat);
        check("doneclr_irq", irq, 1'b0);
        apb(16'h5004, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("doneclr_status", rd, 32'h0);

        // Reset mid-fill
        apb(16'h5000, 1'b1, 32'h1234_0001, 4'hF, rd, err, lat);
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("rstfill_we", map_we, 1'b0);
        check("rstfill_addr", map_addr, 12'h0);
        rst  = 1'b0;
        cnt0 = map_we_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("rstfill_no_we", map_we_cnt - cnt0, 0);
        check("rstfill_cell10", map_mem[10], 16'h1234);
        check("rstfill_cell2000", map_mem[2000], 16'h0707);
        apb(16'h5004, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("rstfill_status", rd, 32'h0);
        apb(16'h5000, 1'b0, 32'h0, 4'h0, rd, err, lat);
        check("rstfill_ctrl", rd, 32'h0);

        // Reset mid read-modify-write on glyph 0x42
        gcnt0 = gly_we_cnt;
        @(posedge clk); #1;
        paddr = 16'h4420; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check("rstrmw_we", glyph_we, 1'b0);
        check("rstrmw_pready", pready, 1'b0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rstrmw_no_we", gly_we_cnt - gcnt0, 0);
        check("rstrmw_mem", glyph_mem[8'h42], 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
